seq_ctrl: RTL

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/instruction_pkg.sv | 34 +++
 rtl/seq_decode.sv | 32 +++
 rtl/seq_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/instruction_pkg.sv
// instruction_pkg: shared RV32I instruction-field constants plus the
// sequencer state encoding and datapath mux select encodings.
//   OPC_*       : 5-bit major opcode, instruction bits [6:2]
//   F3_*        : funct3, instruction bits [14:12]
//   state_e     : seq_ctrl FSM state
//   PC_SEL_*    : seq_ctrl pc_sel encoding
//   WB_SEL_*    : seq_ctrl wb_sel encoding
package instruction_pkg;

  // Low two bits of every 32-bit (non-compressed) instruction.
  localparam logic [1:0] INSN_32BIT = 2'b11;

  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_TRAP  = 3'd4
  } state_e;

  localparam logic PC_SEL_PLUS4  = 1'b0;  // PC + 4
  localparam logic PC_SEL_BRANCH = 1'b1;  // PC + B-immediate

  localparam logic WB_SEL_ALU  = 1'b0;    // rs1 + I-immediate (ADDI)
  localparam logic WB_SEL_UIMM = 1'b1;    // U-immediate (LUI)

endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational decode of the latched instruction.
// Only the low 15 bits (quadrant, opcode, rd, funct3) take part in
// classifying the supported subset, so only those are brought in.
//   ir      in  : instruction bits [14:0]
//   legal   out : instruction is one of ADDI, LUI, BNE
//   is_addi out : OP-IMM with funct3 = ADDI
//   is_lui  out : LUI
//   is_bne  out : BRANCH with funct3 = BNE
module seq_decode
  import instruction_pkg::*;
(
  input  logic [14:0] ir,
  output logic        legal,
  output logic        is_addi,
  output logic        is_lui,
  output logic        is_bne
);

  logic       quad_ok;
  logic [4:0] opcode;
  logic [2:0] funct3;

  assign quad_ok = (ir[1:0] == INSN_32BIT);
  assign opcode  = ir[6:2];
  assign funct3  = ir[14:12];

  assign is_addi = quad_ok && (opcode == OPC_OPIMM)  && (funct3 == F3_ADDI);
  assign is_lui  = quad_ok && (opcode == OPC_LUI);
  assign is_bne  = quad_ok && (opcode == OPC_BRANCH) && (funct3 == F3_BNE);
  assign legal   = is_addi || is_lui || is_bne;

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle instruction sequencer for an ADDI/LUI/BNE subset.
// Fetches over a req/ack port, decodes, strobes the PC and register file,
// counts retired instructions and traps on anything it cannot execute.
//
// Fetch handshake: imem_req is high for every cycle spent in FETCH and only
// drops after the cycle in which imem_ack is seen high; imem_rdata is taken
// in that same cycle. imem_ack outside FETCH is ignored.
//
//   clk, reset_n        : clock, synchronous active-low reset
//   run                 : level enable; sampled when an instruction retires
//   imem_req/ack/rdata  : instruction fetch port
//   br_ne               : rs1 != rs2 from the datapath, used in EXEC for BNE
//   ir                  : latched instruction
//   pc_we, pc_sel       : PC write strobe and next-PC select
//   rf_we, wb_sel       : register-file write strobe and write-back select
//   illegal             : sticky illegal-instruction flag (cleared by reset)
//   instret             : retired-instruction counter, wraps silently
//   state_dbg           : current FSM state
module seq_ctrl
  import instruction_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            br_ne,
  output logic [XLEN-1:0] ir,
  output logic            pc_we,
  output logic            pc_sel,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            illegal,
  output logic [XLEN-1:0] instret,
  output state_e          state_dbg
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   instret_q, instret_d;

  logic              dec_legal, dec_addi, dec_lui, dec_bne;

  seq_decode u_decode (
    .ir      (ir_q[14:0]),
    .legal   (dec_legal),
    .is_addi (dec_addi),
    .is_lui  (dec_lui),
    .is_bne  (dec_bne)
  );

  // Strobes are decoded from the registered state and instruction only, so
  // they are clean single-cycle pulses tied to EXEC/WB. The one exception is
  // pc_sel for BNE, which has to follow br_ne within the EXEC cycle because
  // the datapath compare is only valid once ir has been latched.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    instret_d = instret_q;
    imem_req  = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PLUS4;
    rf_we     = 1'b0;
    wb_sel    = WB_SEL_ALU;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      // run is deliberately not looked at here: a started fetch completes.
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        wb_sel = dec_lui ? WB_SEL_UIMM : WB_SEL_ALU;
        if (!dec_legal) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else if (dec_bne) begin
          pc_we     = 1'b1;
          pc_sel    = br_ne;
          instret_d = instret_q + XLEN'(1);
          state_d   = run ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end

      S_WB: begin
        wb_sel    = dec_lui ? WB_SEL_UIMM : WB_SEL_ALU;
        pc_we     = 1'b1;
        rf_we     = (ir_q[11:7] != 5'd0);  // writes to x0 are dropped
        instret_d = instret_q + XLEN'(1);
        state_d   = run ? S_FETCH : S_IDLE;
      end

      S_TRAP: begin
        // Absorbing: only reset leaves this state.
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  assign ir        = ir_q;
  assign illegal   = illegal_q;
  assign instret   = instret_q;
  assign state_dbg = state_q;

endmodule
